newton_refine: RTL and testbench

- Refinement stage directly downstream of the rough square-root estimator.
- Takes the original IEEE-754 single operand, the estimator's seed and its incorrect flag, and runs ITER Heron/Newton iterations, y <- (y + x/y)/2, in Q2.24 fixed point.
- Uses one shared bit-serial restoring divider and returns a rounded single-precision square root.
- Special operands are resolved by a short bypass path.

---
 rtl/newton_refine_pkg.sv | 55 +++++
 rtl/newton_refine_divider.sv | 87 ++++++++
 rtl/newton_refine.sv | 178 +++++++++++++++++
 tb/tb_newton_refine.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/newton_refine_pkg.sv
// Shared definitions for the Newton/Heron square-root refinement stage.
// Holds IEEE-754 single field positions, special encodings, the Q2.24
// fixed-point geometry, the FSM state encoding and operand classifiers.
package newton_refine_pkg;

  // IEEE-754 single-precision fields
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_W   = 23;
  localparam int BIAS     = 127;

  // Special result encodings
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;
  localparam logic [31:0] PINF  = 32'h7F80_0000;
  localparam logic [31:0] PZERO = 32'h0000_0000;
  localparam logic [31:0] NZERO = 32'h8000_0000;

  // Q2.24 fixed point: 2 integer bits, FRAC fraction bits
  localparam int FRAC = 24;
  localparam int QW   = 26;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_DIV,
    S_UPDATE,
    S_ROUND,
    S_SPECIAL
  } state_t;

  // Anything other than a positive normal number takes the bypass path.
  function automatic logic is_special(input logic [31:0] f, input logic inc);
    logic [7:0] e;
    e = f[EXP_MSB:EXP_LSB];
    return inc || f[SIGN_BIT] || (e == 8'h00) || (e == 8'hFF);
  endfunction

  // Returns {nan_flag, result} for a special operand.
  function automatic logic [32:0] special_result(input logic [31:0] f, input logic inc);
    logic [7:0]        e;
    logic [MANT_W-1:0] m;
    e = f[EXP_MSB:EXP_LSB];
    m = f[MANT_W-1:0];
    if (inc || ((e == 8'hFF) && (m != '0)) || (f[SIGN_BIT] && ((e != 8'h00) || (m != '0))))
      return {1'b1, QNAN};
    else if (e == 8'hFF)
      return {1'b0, PINF};
    else if (f[SIGN_BIT])
      return {1'b0, NZERO};
    else
      return {1'b0, PZERO};  // +0 and positive denormals flush to +0
  endfunction

endpackage

// File: rtl/newton_refine_divider.sv
// restoring_divider_serial: bit-serial restoring divider producing
// Q = ({dividend_hi, FRAC zeros}) / divisor, truncated, one quotient bit per
// cycle MSB first over QW cycles.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         load operands (ignored while busy)
//   dividend_hi   high QW bits of the dividend (low FRAC bits are zero)
//   divisor       QW-bit divisor, must exceed dividend_hi>>2
//   busy          high while quotient bits are being produced
//   done          high during the final step; quotient valid from next cycle
//   quotient      QW-bit quotient, held until the next start
module restoring_divider_serial
  import newton_refine_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [QW-1:0] dividend_hi,
  input  logic [QW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient
);

  logic [QW-1:0] rem_q, rem_d;
  logic [QW-1:0] low_q, low_d;   // dividend bits not yet brought down
  logic [QW-1:0] dvs_q, dvs_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [QW:0]   trial;
  logic [QW-1:0] diff;
  logic          ge;

  always_comb begin
    trial  = {rem_q, low_q[QW-1]};
    ge     = (trial >= {1'b0, dvs_q});
    // When ge is set the true difference fits in QW bits, so modular
    // subtraction on the low bits is exact.
    diff   = trial[QW-1:0] - dvs_q;
    rem_d  = rem_q;
    low_d  = low_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start && !busy_q) begin
      // The top 24 dividend bits seed the remainder; they are below the
      // divisor, so the quotient fits in QW bits.
      rem_d  = {2'b00, dividend_hi[QW-1:2]};
      low_d  = {dividend_hi[1:0], {(QW-2){1'b0}}};
      dvs_d  = divisor;
      quo_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = ge ? diff : trial[QW-1:0];
      low_d = {low_q[QW-2:0], 1'b0};
      quo_d = {quo_q[QW-2:0], ge};
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'(QW - 1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      low_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      low_q  <= low_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == 5'(QW - 1));
  assign quotient = quo_q;

endmodule

// File: rtl/newton_refine.sv
// newton_refine: refines an upstream square-root seed with ITER Heron
// iterations y <- (y + x/y)/2 in Q2.24 and returns a rounded single.
// Special operands bypass the datapath and resolve in one cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request, sampled only while busy=0
//   in                  original IEEE-754 single operand
//   estimate            seed from the upstream estimator
//   incorrect_in        upstream invalid-operand flag
//   busy                high from accept until the done edge
//   done                one-cycle pulse, out/incorrect_out valid
//   out                 result, held until the next done
//   incorrect_out       result is NaN, held with out
module newton_refine
  import newton_refine_pkg::*;
#(
  parameter int ITER = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] in,
  input  logic [31:0] estimate,
  input  logic        incorrect_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        incorrect_out
);

  state_t        state_q, state_d;
  logic [31:0]   in_q, in_d;
  logic [31:0]   est_q, est_d;
  logic          inc_q, inc_d;
  logic [QW-1:0] x_q, x_d;
  logic [QW-1:0] y_q, y_d;
  logic [7:0]    er_q, er_d;
  logic [2:0]    iter_q, iter_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [31:0]   out_q, out_d;
  logic          incorrect_q, incorrect_d;

  logic          div_start, div_busy, div_done;
  logic [QW-1:0] div_q;
  logic [7:0]    in_exp, est_exp;
  logic [24:0]   rnd;
  logic [32:0]   spec;

  always_comb begin
    state_d     = state_q;
    in_d        = in_q;
    est_d       = est_q;
    inc_d       = inc_q;
    x_d         = x_q;
    y_d         = y_q;
    er_d        = er_q;
    iter_d      = iter_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_d       = out_q;
    incorrect_d = incorrect_q;
    div_start   = 1'b0;
    in_exp      = in_q[EXP_MSB:EXP_LSB];
    est_exp     = est_q[EXP_MSB:EXP_LSB];
    // Round half up on Y[0]; bits [24:23] must stay 01 or the mantissa saturates.
    rnd         = 25'(y_q[QW-1:1]) + 25'(y_q[0]);
    spec        = special_result(in_q, inc_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          in_d    = in;
          est_d   = estimate;
          inc_d   = incorrect_in;
          busy_d  = 1'b1;
          state_d = is_special(in, incorrect_in) ? S_SPECIAL : S_PREP;
        end
      end
      S_SPECIAL: begin
        {incorrect_d, out_d} = spec;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_PREP: begin
        // Biased exponent even means unbiased exponent odd: fold one factor of 2 into X.
        if (!in_exp[0])
          x_d = {1'b1, in_q[MANT_W-1:0], {(FRAC-MANT_W+1){1'b0}}};
        else
          x_d = {2'b01, in_q[MANT_W-1:0], {(FRAC-MANT_W){1'b0}}};
        // floor((exp-127)/2)+127 == floor((exp+127)/2)
        er_d = 8'(({1'b0, in_exp} + 9'(BIAS)) >> 1);
        if (est_q[SIGN_BIT])
          y_d = QW'(1) << FRAC;
        else if (est_exp == er_d)
          y_d = {2'b01, est_q[MANT_W-1:0], {(FRAC-MANT_W){1'b0}}};
        else if ({1'b0, est_exp} == ({1'b0, er_d} + 9'd1))
          y_d = {1'b0, {(QW-1){1'b1}}};  // seed one binade high: clamp just below 2.0
        else
          y_d = QW'(1) << FRAC;
        iter_d    = '0;
        div_start = 1'b1;
        state_d   = S_DIV;
      end
      S_DIV: begin
        if (div_busy && div_done) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        y_d = QW'(({1'b0, y_q} + {1'b0, div_q}) >> 1);
        if (iter_q < 3'(ITER - 1)) begin
          iter_d    = iter_q + 3'd1;
          div_start = 1'b1;
          state_d   = S_DIV;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        out_d       = {1'b0, er_q, (rnd[24:23] != 2'b01) ? {MANT_W{1'b1}} : rnd[MANT_W-1:0]};
        incorrect_d = 1'b0;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_q        <= '0;
      est_q       <= '0;
      inc_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      er_q        <= '0;
      iter_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_q       <= '0;
      incorrect_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_q        <= in_d;
      est_q       <= est_d;
      inc_q       <= inc_d;
      x_q         <= x_d;
      y_q         <= y_d;
      er_q        <= er_d;
      iter_q      <= iter_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_q       <= out_d;
      incorrect_q <= incorrect_d;
    end
  end

  // Operands are the values being loaded this edge, so division starts
  // in the same edge that enters DIV.
  restoring_divider_serial u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (div_start),
    .dividend_hi (x_d),
    .divisor     (y_d),
    .busy        (div_busy),
    .done        (div_done),
    .quotient    (div_q)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign out           = out_q;
  assign incorrect_out = incorrect_q;

endmodule

// File: tb/tb_newton_refine.sv
// Scoreboard bench for newton_refine: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is seen.
module tb_newton_refine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] in_v = '0;
  logic [31:0] estimate = '0;
  logic        incorrect_in = 1'b0;
  logic        busy, done, incorrect_out;
  logic [31:0] out;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] val;
    logic        nan;
    int          tol;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];

  localparam int LAT_N = 2 + 27 * 5;  // 137
  localparam int LAT_S = 1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  newton_refine #(.ITER(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .in            (in_v),
    .estimate      (estimate),
    .incorrect_in  (incorrect_in),
    .busy          (busy),
    .done          (done),
    .out           (out),
    .incorrect_out (incorrect_out)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor / scoreboard
  exp_t        m_e;
  logic [31:0] m_d;
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got out=%h with no pending request", out);
      end else begin
        m_e = sb.pop_front();
        m_d = (out > m_e.val) ? (out - m_e.val) : (m_e.val - out);
        checks++;
        if (m_d > 32'(m_e.tol)) begin
          errors++;
          $display("FAIL %s_out: got %h expected %h (tol %0d)", m_e.name, out, m_e.val, m_e.tol);
        end
        check({m_e.name, "_nan"}, {31'b0, incorrect_out}, {31'b0, m_e.nan});
        check({m_e.name, "_latency"}, 32'(cyc), 32'(m_e.due));
        check({m_e.name, "_busy_at_done"}, {31'b0, busy}, 32'h0);
        $display("txn %s: out=%h incorrect=%0b cycle=%0d (expected %h/%0b at %0d)",
                 m_e.name, out, incorrect_out, cyc, m_e.val, m_e.nan, m_e.due);
      end
    end
  end

  // Called at a negedge; start is sampled at the next posedge.
  task automatic issue(input string nm, input logic [31:0] a, input logic [31:0] e, input logic inc,
                       input logic [31:0] xo, input logic xn, input int tol, input int lat);
    exp_t x;
    x.val = xo; x.nan = xn; x.tol = tol; x.due = cyc + 1 + lat; x.name = nm;
    sb.push_back(x);
    in_v = a; estimate = e; incorrect_in = inc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy_after_accept"}, {31'b0, busy}, 32'h1);
  endtask

  task automatic drain(input string nm);
    int i;
    for (i = 0; i < 400; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", nm, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done(input string nm);
    int i;
    for (i = 0; i < 400; i++) begin
      if (done) break;
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_wait_done: got done=0 expected 1 within 400 cycles", nm);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_out", out, 32'h0);
    check("reset_nan", {31'b0, incorrect_out}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal operands
    issue("sqrt64", 32'h42800000, 32'h41000000, 1'b0, 32'h41000000, 1'b0, 0, LAT_N);
    drain("sqrt64");
    issue("sqrt50625", 32'h4745C100, 32'h3F800000, 1'b0, 32'h43610000, 1'b0, 0, LAT_N);
    drain("sqrt50625");
    issue("sqrt0p0625", 32'h3D800000, 32'h3E800000, 1'b0, 32'h3E800000, 1'b0, 0, LAT_N);
    drain("sqrt0p0625");
    issue("sqrt2", 32'h40000000, 32'h3F800000, 1'b0, 32'h3FB504F3, 1'b0, 1, LAT_N);
    drain("sqrt2");

    // Special operands
    issue("neg_inf", 32'hFF800000, 32'h0, 1'b0, 32'h7FC00000, 1'b1, 0, LAT_S);
    drain("neg_inf");
    issue("snan", 32'h7FA6ED6A, 32'h0, 1'b0, 32'h7FC00000, 1'b1, 0, LAT_S);
    drain("snan");
    issue("pos_inf", 32'h7F800000, 32'h0, 1'b0, 32'h7F800000, 1'b0, 0, LAT_S);
    drain("pos_inf");
    issue("neg_zero", 32'h80000000, 32'h0, 1'b0, 32'h80000000, 1'b0, 0, LAT_S);
    drain("neg_zero");
    issue("denorm", 32'h00000001, 32'h0, 1'b0, 32'h00000000, 1'b0, 0, LAT_S);
    drain("denorm");
    issue("flag_in", 32'h42800000, 32'h41000000, 1'b1, 32'h7FC00000, 1'b1, 0, LAT_S);
    drain("flag_in");

    // Start while busy is ignored
    issue("ignore_busy", 32'h42800000, 32'h41000000, 1'b0, 32'h41000000, 1'b0, 0, LAT_N);
    repeat (9) @(negedge clk);
    in_v = 32'h4745C100; estimate = 32'h3F800000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("ignore_busy");

    // Back-to-back: second start in the done cycle
    issue("b2b_first", 32'h41800000, 32'h40800000, 1'b0, 32'h40800000, 1'b0, 0, LAT_N);
    wait_done("b2b_first");
    issue("b2b_second", 32'h42800000, 32'h41000000, 1'b0, 32'h41000000, 1'b0, 0, LAT_N);
    drain("b2b_second");

    // Reset mid-operation aborts without a done pulse
    issue("aborted", 32'h4745C100, 32'h3F800000, 1'b0, 32'h43610000, 1'b0, 0, LAT_N);
    repeat (48) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    check("abort_out", out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    issue("after_reset", 32'h4745C100, 32'h3F800000, 1'b0, 32'h43610000, 1'b0, 0, LAT_N);
    drain("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
